// File: rtl/mips_regfile_pkg.sv
// Shared constants and types for the multi-port MIPS register file.
// Optional build macro: MIPS_REGFILE_BYPASS_EN (write-through read forwarding).
package mips_regfile_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_NUM_REGS = 32;
   localparam int unsigned DEF_NUM_RD   = 2;

   // Hardwired zero register index
   localparam int unsigned ZERO_REG = 0;

   // Per-register scoreboard state: IDLE = value settled, PEND = write in flight
   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } busyState_e;

endpackage

// File: rtl/mips_regfile_rdport.sv
// Single combinational read port: register select, zero-register masking and
// optional same-cycle write forwarding (MIPS_REGFILE_BYPASS_EN).
module mips_regfile_rdport
   import mips_regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic [ADDR_W-1:0]          rdAddr,
   input  logic [NUM_REGS*DATA_W-1:0] regFlat,
   input  logic [NUM_REGS-1:0]        busyVec,
   input  logic                       wrEn,
   input  logic [ADDR_W-1:0]          wrAddr,
   input  logic [DATA_W-1:0]          wrData,
   output logic [DATA_W-1:0]          rdData,
   output logic                       rdBusy
);

   // Select stored value and busy bit; r0 always reads zero and never busy
   always_comb begin
      rdData = regFlat[int'(rdAddr)*DATA_W +: DATA_W];
      rdBusy = busyVec[rdAddr];
      if (rdAddr == ADDR_W'(ZERO_REG)) begin
         rdData = '0;
         rdBusy = 1'b0;
      end
`ifdef MIPS_REGFILE_BYPASS_EN
      else if (wrEn && (wrAddr == rdAddr)) begin
         rdData = wrData;
         rdBusy = 1'b0;
      end
`endif
   end

`ifndef MIPS_REGFILE_BYPASS_EN
   logic unusedWrSide;
   assign unusedWrSide = ^{wrEn, wrAddr, wrData};
`endif

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port register file with pending-write scoreboard.
// Optional build macro: MIPS_REGFILE_BYPASS_EN (write-through read forwarding).
module mips_regfile_mp
   import mips_regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
   parameter int unsigned NUM_RD   = DEF_NUM_RD
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
   output logic [NUM_RD*DATA_W-1:0] RdData,
   output logic [NUM_RD-1:0]        RdBusy,
   input  logic                     IssEn,
   input  logic [ADDR_W-1:0]        IssAddr,
   output logic                     IssReady,
   input  logic                     WrEn,
   input  logic [ADDR_W-1:0]        WrAddr,
   input  logic [DATA_W-1:0]        WrData,
   output logic [ADDR_W:0]          PendCnt
);

   logic [DATA_W-1:0]          regMem [NUM_REGS];
   logic [NUM_REGS*DATA_W-1:0] regFlat;
   busyState_e                 busyQ [NUM_REGS];
   busyState_e                 busyD [NUM_REGS];
   logic [NUM_REGS-1:0]        busyVec;
   logic [ADDR_W:0]            pendCntQ;
   logic [ADDR_W:0]            pendCntD;
   logic                       issAccept;
   logic                       cntInc;
   logic                       cntDec;
   logic                       wrEnFwd;

   // Flatten storage and scoreboard for the read ports
   always_comb begin
      regFlat = '0;
      busyVec = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         regFlat[r*DATA_W +: DATA_W] = regMem[r];
         busyVec[r]                  = (busyQ[r] == PEND);
      end
   end

   // Issue handshake: free target, target being retired this edge, or r0
   always_comb begin
      IssReady  = (IssAddr == ADDR_W'(ZERO_REG)) || !busyVec[IssAddr] ||
                  (WrEn && (WrAddr == IssAddr));
      issAccept = IssEn && IssReady;
   end

   // Data storage: writeback updates, r0 stays zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            regMem[r] <= '0;
         end
      end else if (WrEn && (WrAddr != ADDR_W'(ZERO_REG))) begin
         regMem[WrAddr] <= WrData;
      end
   end

   // Scoreboard next state: write retires, accepted issue re-arms (issue wins)
   always_comb begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         busyD[r] = busyQ[r];
      end
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
         if (issAccept && (IssAddr == ADDR_W'(r))) begin
            busyD[r] = PEND;
         end else if (WrEn && (WrAddr == ADDR_W'(r))) begin
            busyD[r] = IDLE;
         end
      end
      // Same-register issue+write on a busy entry counts both ways: net zero
      cntInc   = issAccept && (IssAddr != ADDR_W'(ZERO_REG));
      cntDec   = WrEn && (WrAddr != ADDR_W'(ZERO_REG)) && busyVec[WrAddr];
      pendCntD = pendCntQ + (ADDR_W+1)'(cntInc) - (ADDR_W+1)'(cntDec);
   end

   // Scoreboard and pending-count state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busyQ[r] <= IDLE;
         end
         pendCntQ <= '0;
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busyQ[r] <= busyD[r];
         end
         pendCntQ <= pendCntD;
      end
   end

   assign PendCnt = pendCntQ;

   // Forwarding is suppressed while reset is held so reads stay zero
   assign wrEnFwd = WrEn && rst_n;

   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rdPort
         mips_regfile_rdport #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W)
         ) u_rdPort (
            .rdAddr  (RdAddr[gi*ADDR_W +: ADDR_W]),
            .regFlat (regFlat),
            .busyVec (busyVec),
            .wrEn    (wrEnFwd),
            .wrAddr  (WrAddr),
            .wrData  (WrData),
            .rdData  (RdData[gi*DATA_W +: DATA_W]),
            .rdBusy  (RdBusy[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Scoreboard bench for mips_regfile_mp: stimulus pushes predicted outputs,
// a negedge monitor pops and compares.
module tb_mips_regfile_mp;

   localparam int DW  = 32;
   localparam int NR  = 32;
   localparam int AW  = 5;
   localparam int NRD = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NRD*AW-1:0] RdAddr;
   logic [NRD*DW-1:0] RdData;
   logic [NRD-1:0]    RdBusy;
   logic              IssEn;
   logic [AW-1:0]     IssAddr;
   logic              IssReady;
   logic              WrEn;
   logic [AW-1:0]     WrAddr;
   logic [DW-1:0]     WrData;
   logic [AW:0]       PendCnt;

   always #5 clk = ~clk;

   mips_regfile_mp #(
      .DATA_W   (DW),
      .NUM_REGS (NR),
      .NUM_RD   (NRD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .RdAddr   (RdAddr),
      .RdData   (RdData),
      .RdBusy   (RdBusy),
      .IssEn    (IssEn),
      .IssAddr  (IssAddr),
      .IssReady (IssReady),
      .WrEn     (WrEn),
      .WrAddr   (WrAddr),
      .WrData   (WrData),
      .PendCnt  (PendCnt)
   );

   typedef struct {
      logic [NRD*DW-1:0] data;
      logic [NRD-1:0]    busy;
      logic              issReady;
      logic [AW:0]       pend;
      string             name;
   } exp_t;

   exp_t          sbQ[$];
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] mReg [NR];
   bit            mBusy [NR];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic modelClear();
      for (int r = 0; r < NR; r++) begin
         mReg[r]  = '0;
         mBusy[r] = 1'b0;
      end
   endtask

   // Reference: outputs follow directly from the stated read/issue rules
   function automatic exp_t predict(input string name);
      exp_t e;
      int   cnt = 0;
      e.name = name;
      e.data = '0;
      e.busy = '0;
      for (int i = 0; i < NRD; i++) begin
         logic [AW-1:0] a;
         a = RdAddr[i*AW +: AW];
         if (!rst_n || a == 0) begin
            e.data[i*DW +: DW] = '0;
            e.busy[i]          = 1'b0;
         end
`ifdef MIPS_REGFILE_BYPASS_EN
         else if (WrEn && WrAddr == a) begin
            e.data[i*DW +: DW] = WrData;
            e.busy[i]          = 1'b0;
         end
`endif
         else begin
            e.data[i*DW +: DW] = mReg[a];
            e.busy[i]          = mBusy[a];
         end
      end
      e.issReady = !rst_n || IssAddr == 0 || !mBusy[IssAddr] || (WrEn && WrAddr == IssAddr);
      for (int r = 0; r < NR; r++) cnt += int'(mBusy[r]);
      e.pend = (AW+1)'(cnt);
      return e;
   endfunction

   // Clock edge: apply write then accepted issue to the model
   task automatic advance();
      bit acc;
      @(posedge clk);
      if (rst_n) begin
         acc = IssEn && (IssAddr == 0 || !mBusy[IssAddr] || (WrEn && WrAddr == IssAddr));
         if (WrEn && WrAddr != 0) begin
            mReg[WrAddr]  = WrData;
            mBusy[WrAddr] = 1'b0;
         end
         if (acc && IssAddr != 0) mBusy[IssAddr] = 1'b1;
      end
      #1;
   endtask

   task automatic step(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic ie, input logic [AW-1:0] ia,
                       input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input string name);
      RdAddr  = {r1, r0};
      IssEn   = ie;
      IssAddr = ia;
      WrEn    = we;
      WrAddr  = wa;
      WrData  = wd;
      sbQ.push_back(predict(name));
      advance();
   endtask

   // Monitor: compare DUT outputs against queued predictions mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         if (sbQ.size() > 0) begin
            exp_t e;
            e = sbQ.pop_front();
            for (int i = 0; i < NRD; i++) begin
               chk($sformatf("%s.data%0d", e.name, i), 64'(RdData[i*DW +: DW]), 64'(e.data[i*DW +: DW]));
               chk($sformatf("%s.busy%0d", e.name, i), 64'(RdBusy[i]), 64'(e.busy[i]));
            end
            chk($sformatf("%s.issReady", e.name), 64'(IssReady), 64'(e.issReady));
            chk($sformatf("%s.pendCnt", e.name), 64'(PendCnt), 64'(e.pend));
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      RdAddr  = '0;
      IssEn   = 1'b0;
      IssAddr = '0;
      WrEn    = 1'b0;
      WrAddr  = '0;
      WrData  = '0;
      modelClear();
      @(posedge clk);
      #1;
      step(5'd5, 5'd9, 1'b1, 5'd5, 1'b1, 5'd9, 32'hCAFE_F00D, "rstHeld");
      rst_n = 1'b1;

      for (int a = 0; a < NR; a++)
         step(5'(a), 5'(NR-1-a), 1'b0, '0, 1'b0, '0, '0, "rstRead");

      step(5'd0, 5'd0, 1'b0, '0, 1'b1, 5'd2, 32'h0000_FFFF, "wrR2");
      step(5'd0, 5'd0, 1'b0, '0, 1'b1, 5'd3, 32'hFFFF_FFFF, "wrR3");
      step(5'd2, 5'd3, 1'b0, '0, 1'b0, '0, '0, "rdR2R3");
      step(5'd0, 5'd0, 1'b0, '0, 1'b1, 5'd0, 32'hDEAD_BEEF, "wrR0");
      step(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, '0, '0, "rdR0issR0");

      step(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, '0, '0, "issR5");
      step(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, '0, '0, "reissR5");
      step(5'd5, 5'd0, 1'b0, '0, 1'b1, 5'd5, 32'h0000_1234, "wrR5");
      step(5'd5, 5'd0, 1'b0, '0, 1'b0, '0, '0, "rdR5");

      step(5'd7, 5'd0, 1'b1, 5'd7, 1'b0, '0, '0, "issR7");
      step(5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 32'h0000_00AA, "issWrR7");
      step(5'd7, 5'd7, 1'b0, '0, 1'b0, '0, '0, "rdR7");

      step(5'd0, 5'd0, 1'b0, '0, 1'b1, 5'd4, 32'h0000_1111, "wrR4old");
      step(5'd4, 5'd4, 1'b0, '0, 1'b1, 5'd4, 32'h0000_BEEF, "rdWrR4");
      step(5'd4, 5'd0, 1'b0, '0, 1'b0, '0, '0, "rdR4after");

      for (int n = 0; n < 300; n++)
         step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom(),
              "rand");

      for (int a = 1; a <= 3; a++)
         step(5'd0, 5'd0, 1'b0, '0, 1'b1, 5'(a), 32'h100 + 32'(a), "clrR");
      for (int a = 1; a <= 3; a++)
         step(5'(a), 5'd0, 1'b1, 5'(a), 1'b0, '0, '0, "issR123");
      step(5'd1, 5'd3, 1'b0, '0, 1'b0, '0, '0, "preRst");

      RdAddr = {5'd2, 5'd1};
      #2;
      rst_n = 1'b0;
      modelClear();
      sbQ.push_back(predict("midRst"));
      @(posedge clk);
      #1;
      step(5'd3, 5'd2, 1'b1, 5'd3, 1'b0, '0, '0, "rstHeld2");
      rst_n = 1'b1;
      step(5'd1, 5'd2, 1'b0, '0, 1'b0, '0, '0, "postRst");
      step(5'd3, 5'd0, 1'b0, '0, 1'b0, '0, '0, "postRst2");

      repeat (2) @(posedge clk);
      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("FAIL drainQueue actual=%0d required=0", sbQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_regfile_mp.md
# mips_regfile_mp

Parametrised multi-port register file with a pending-write scoreboard for the pipelined MIPS datapath. It replaces the single-cycle two-read/one-write register file. It adds configurable width, depth and read-port count, a hardwired zero register, and per-register busy tracking so decode can detect RAW hazards against in-flight writebacks. It sits between decode (read and issue side) and writeback (write side).

## Interface
Parameters:
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: register count; power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS): register address width (derived).
- NUM_RD, 2: read-port count, 1 to 4.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- RdAddr  in  NUM_RD*ADDR_W  read addresses; port i occupies slice [i*ADDR_W +: ADDR_W].
- RdData  out  NUM_RD*DATA_W  read data, same slicing as RdAddr.
- RdBusy  out  NUM_RD  port i source has a pending write.
- IssEn  in  1  request to mark IssAddr as a pending destination.
- IssAddr  in  ADDR_W  destination register being issued.
- IssReady  out  1  issue can be accepted this cycle.
- WrEn  in  1  writeback strobe.
- WrAddr  in  ADDR_W  writeback register.
- WrData  in  DATA_W  writeback value.
- PendCnt  out  ADDR_W+1  number of registers currently busy.

## Operation
- Storage: NUM_REGS × DATA_W array plus a NUM_REGS-bit busy vector.
- Reads are combinational. RdData[i] = reg[RdAddr[i]], and RdBusy[i] = busy[RdAddr[i]].
- Register 0 always reads 0 and is never busy. Writes and issues to register 0 are accepted but have no effect.
- Write: on a clk rising edge with WrEn, reg[WrAddr] <= WrData and busy[WrAddr] <= 0.
- Issue handshake:
  - IssReady = !busy[IssAddr] || (WrEn && WrAddr == IssAddr), or IssAddr == 0.
  - An issue is accepted when IssEn && IssReady; on that edge busy[IssAddr] <= 1.
  - When IssReady is low, the request is ignored and decode must hold it.
- Simultaneous write and accepted issue to the same nonzero register:
  - The data is written.
  - Busy ends at 1, because the new producer is now in flight.
- Simultaneous write and issue to different registers: both take effect.
- A write to a non-busy register is legal: data is written and busy stays 0.
- PendCnt is a registered population count of the busy vector. It is updated on the same edge: +1 for an accepted nonzero issue, −1 for a clearing write; both together give a net 0.
- Reset assertion, at any time including mid-operation:
  - All registers go to 0, busy goes to all 0, PendCnt goes to 0, immediately (asynchronous).
  - While reset is held, outputs read 0, RdBusy is 0 and IssReady is 1.

## Timing
- Read latency is 0 cycles (combinational from RdAddr and state).
- Write and issue take effect at the rising edge and are visible on reads after that edge.
- Without bypass, a read in the same cycle as a write to the same address returns the old value.
- Reset release is synchronous to the next edge; the first write or issue is sampled on the first edge after rst_n rises.
- No multi-cycle states. The busy vector acts as NUM_REGS independent 2-state machines (IDLE↔PEND): IDLE→PEND on accepted issue, PEND→IDLE on write without a same-cycle issue.

## Configuration
- MIPS_REGFILE_BYPASS_EN defined:
  - Write-through forwarding. If WrEn && WrAddr == RdAddr[i] != 0, then RdData[i] = WrData and RdBusy[i] = 0 in the same cycle.
- Undefined: no forwarding; same-cycle reads return stored data and the registered busy bit.
- Issue acceptance is identical in both builds.

## Structure
- Shared package mips_regfile_pkg holds:
  - default constants (DATA_W, NUM_REGS, NUM_RD);
  - the zero-register index constant;
  - the typedef for the busy-state enum (IDLE, PEND).
- One sub-module: mips_regfile_rdport, the per-port read mux with zero-register and bypass logic, instantiated NUM_RD times with a generate loop.

## Test plan
- Reset, then read all registers on every port → every RdData = 0, every RdBusy = 0, PendCnt = 0.
- Write 0x0000FFFF to r2, then write 0xFFFFFFFF to r3; read r2 on port 0 and r3 on port 1 → 0x0000FFFF and 0xFFFFFFFF; a write to r0 followed by a read of r0 → 0.
- Issue r5; next cycle issue r5 again → IssReady = 0, PendCnt = 1, RdBusy = 1 for r5. Write 0x1234 to r5 → busy clears, PendCnt = 0, a read of r5 gives 0x1234.
- Same cycle: issue r7 and write r7 = 0xAA while r7 is busy → data 0xAA stored, r7 still busy, PendCnt unchanged.
- Same-cycle read of r4 while writing r4 = 0xBEEF:
  - BYPASS_EN build: 0xBEEF with busy 0.
  - Non-bypass build: old value, with BEEF visible after the edge.
- Issue r1, r2 and r3, then assert rst_n low mid-cycle → all data and busy bits clear immediately and PendCnt = 0.
